// File: rtl/kf8259_common_pkg.sv
// Shared types, constants and bit-vector helpers for the KF8259 interrupt
// request/service path.
//   IR_WIDTH      : number of interrupt request levels
//   trig_mode_e   : trigger mode of the IR inputs
//   bit2num       : one-hot vector to level number
//   rotate_right  : 8-bit rotate toward bit 0
//   rotate_left   : 8-bit rotate toward bit 7
//   find_first_one: isolate the lowest set bit
package kf8259_common_pkg;

    localparam int unsigned IR_WIDTH = 8;

    typedef enum logic {
        TRIG_EDGE  = 1'b0,
        TRIG_LEVEL = 1'b1
    } trig_mode_e;

    function automatic logic [2:0] bit2num(input logic [7:0] onehot);
        logic [2:0] num;
        num = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) num = num | 3'(i);
        end
        return num;
    endfunction

    function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] d;
        d = {v, v} >> n;
        return d[7:0];
    endfunction

    function automatic logic [7:0] rotate_left(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] find_first_one(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/kf8259_priority_select.sv
// Rotating priority resolver: returns the one-hot highest-priority set bit
// of request_vector, where level (priority_rotate+1) mod 8 is the highest.
//   request_vector  in  8  candidate levels
//   priority_rotate in  3  lowest-priority level number
//   highest_bit     out 8  one-hot winner, or 0
module kf8259_priority_select
    import kf8259_common_pkg::*;
(
    input  logic [IR_WIDTH-1:0] request_vector,
    input  logic [2:0]          priority_rotate,
    output logic [IR_WIDTH-1:0] highest_bit
);

    logic [2:0]          shift;
    logic [IR_WIDTH-1:0] rotated;

    // Rotate so the highest-priority level lands on bit 0, pick the lowest
    // set bit, then rotate the one-hot result back into place.
    assign shift       = priority_rotate + 3'd1;
    assign rotated     = rotate_right(request_vector, shift);
    assign highest_bit = rotate_left(find_first_one(rotated), shift);

endmodule

// File: rtl/kf8259_request_service_core.sv
// KF8259 interrupt request / in-service stage: synchronises IR pins, holds
// IRR and ISR, and resolves the winning request with rotation, masking and
// nesting.
//   clock, reset                    clock; asynchronous active-high reset
//   interrupt_request_pin           raw IR0-IR7 lines
//   level_or_edge_triggered_config  1 = level, 0 = edge triggered
//   freeze                          hold the IRR set path
//   clear_interrupt_request         per-bit IRR clear
//   interrupt_mask                  IMR, 1 masks a level
//   priority_rotate                 lowest-priority level number
//   latch_in_service                copy interrupt into ISR
//   end_of_interrupt                per-bit ISR clear
//   interrupt_request_register      IRR
//   in_service_register             ISR
//   highest_level_in_service        one-hot top ISR bit, or 0
//   interrupt                       one-hot winning request, or 0
module kf8259_request_service_core
    import kf8259_common_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic [IR_WIDTH-1:0] interrupt_request_pin,
    input  logic                level_or_edge_triggered_config,
    input  logic                freeze,
    input  logic [IR_WIDTH-1:0] clear_interrupt_request,
    input  logic [IR_WIDTH-1:0] interrupt_mask,
    input  logic [2:0]          priority_rotate,
    input  logic                latch_in_service,
    input  logic [IR_WIDTH-1:0] end_of_interrupt,
    output logic [IR_WIDTH-1:0] interrupt_request_register,
    output logic [IR_WIDTH-1:0] in_service_register,
    output logic [IR_WIDTH-1:0] highest_level_in_service,
    output logic [IR_WIDTH-1:0] interrupt
);

    logic [IR_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [IR_WIDTH-1:0] prev_q;
    logic [IR_WIDTH-1:0] irr_q, irr_d;
    logic [IR_WIDTH-1:0] isr_q, isr_d;
    logic [IR_WIDTH-1:0] pend_q, pend_d;
    trig_mode_e          mode_q;
    trig_mode_e          mode_now;

    logic [IR_WIDTH-1:0] sync_out;
    logic [IR_WIDTH-1:0] rise;
    logic [IR_WIDTH-1:0] winner;
    logic [IR_WIDTH-1:0] isr_top;
    logic [2:0]          shift;
    logic                winner_outranks;

    assign mode_now = trig_mode_e'(level_or_edge_triggered_config);
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
            irr_q  <= '0;
            isr_q  <= '0;
            pend_q <= '0;
            mode_q <= TRIG_EDGE;
        end else begin
            sync_q[0] <= interrupt_request_pin;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_out;
            irr_q  <= irr_d;
            isr_q  <= isr_d;
            pend_q <= pend_d;
            mode_q <= mode_now;
        end
    end

    // Edges seen while frozen are parked in pend_q and merged into IRR on the
    // first unfrozen cycle; clear always wins over both paths.
    always_comb begin
        irr_d  = irr_q;
        pend_d = '0;
        if (mode_now == TRIG_LEVEL) begin
            if (!freeze) irr_d = sync_out;
        end else begin
            if (freeze) pend_d = pend_q | rise;
            else        irr_d  = irr_q | rise | pend_q;
            if (mode_now != mode_q) pend_d = '0;
        end
        irr_d  = irr_d  & ~clear_interrupt_request;
        pend_d = pend_d & ~clear_interrupt_request;
    end

    kf8259_priority_select u_isr_select (
        .request_vector  (isr_q),
        .priority_rotate (priority_rotate),
        .highest_bit     (isr_top)
    );

    kf8259_priority_select u_irr_select (
        .request_vector  (irr_q & ~interrupt_mask),
        .priority_rotate (priority_rotate),
        .highest_bit     (winner)
    );

    // In the rotated frame a lower bit position means higher priority, so
    // comparing rotated one-hot values ranks the two levels; equal loses.
    assign shift           = priority_rotate + 3'd1;
    assign winner_outranks = (rotate_right(winner, shift) < rotate_right(isr_top, shift));
    assign interrupt       = ((isr_q == '0) || winner_outranks) ? winner : '0;

    always_comb begin
        isr_d = (isr_q & ~end_of_interrupt) | (latch_in_service ? interrupt : '0);
    end

    assign interrupt_request_register = irr_q;
    assign in_service_register        = isr_q;
    assign highest_level_in_service   = isr_top;

endmodule

// File: tb/tb_kf8259_request_service_core.sv
module tb_kf8259_request_service_core;

    localparam int S = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pin   = 8'h00;
    logic       cfg   = 1'b0;
    logic       frz   = 1'b0;
    logic [7:0] clr   = 8'h00;
    logic [7:0] mask  = 8'h00;
    logic [2:0] rot   = 3'd7;
    logic       lat   = 1'b0;
    logic [7:0] eoi   = 8'h00;

    logic [7:0] irr_o, isr_o, hlis_o, int_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic [7:0] m_irr, m_isr, m_pend;
    logic       m_mode;
    logic [7:0] m_pipe[$];

    kf8259_request_service_core #(.SYNC_STAGES(S)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .interrupt_request_pin          (pin),
        .level_or_edge_triggered_config (cfg),
        .freeze                         (frz),
        .clear_interrupt_request        (clr),
        .interrupt_mask                 (mask),
        .priority_rotate                (rot),
        .latch_in_service               (lat),
        .end_of_interrupt               (eoi),
        .interrupt_request_register     (irr_o),
        .in_service_register            (isr_o),
        .highest_level_in_service       (hlis_o),
        .interrupt                      (int_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Walk levels from highest to lowest priority.
    function automatic logic [7:0] model_hlis(input logic [7:0] isr, input logic [2:0] r);
        for (int k = 1; k <= 8; k++) begin
            int lvl;
            lvl = (int'(r) + k) % 8;
            if (isr[lvl]) return 8'(1 << lvl);
        end
        return 8'h00;
    endfunction

    // First level met in priority order decides: in service blocks, request wins.
    function automatic logic [7:0] model_int(input logic [7:0] irr, input logic [7:0] isr,
                                             input logic [7:0] m, input logic [2:0] r);
        for (int k = 1; k <= 8; k++) begin
            int lvl;
            lvl = (int'(r) + k) % 8;
            if (isr[lvl]) return 8'h00;
            if (irr[lvl] && !m[lvl]) return 8'(1 << lvl);
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_irr  = 8'h00;
        m_isr  = 8'h00;
        m_pend = 8'h00;
        m_mode = 1'b0;
        m_pipe.delete();
    endtask

    task automatic model_step();
        logic [7:0] s, p, rs, now_int, n_irr, n_pend;
        s  = (m_pipe.size() >= S)     ? m_pipe[S-1] : 8'h00;
        p  = (m_pipe.size() >= S + 1) ? m_pipe[S]   : 8'h00;
        rs = s & ~p;
        now_int = model_int(m_irr, m_isr, mask, rot);
        m_isr = (m_isr & ~eoi) | (lat ? now_int : 8'h00);
        n_irr  = m_irr;
        n_pend = 8'h00;
        if (cfg) begin
            if (!frz) n_irr = s;
        end else begin
            if (frz) n_pend = m_pend | rs;
            else     n_irr  = m_irr | rs | m_pend;
            if (cfg != m_mode) n_pend = 8'h00;
        end
        m_irr  = n_irr & ~clr;
        m_pend = n_pend & ~clr;
        m_mode = cfg;
        m_pipe.push_front(pin);
        if (m_pipe.size() > S + 1) void'(m_pipe.pop_back());
    endtask

    task automatic check_model();
        check("irr", irr_o, m_irr);
        check("isr", isr_o, m_isr);
        check("hlis", hlis_o, model_hlis(m_isr, rot));
        check("int", int_o, model_int(m_irr, m_isr, mask, rot));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_model();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_irr", irr_o, 8'h00);
        check("rst_isr", isr_o, 8'h00);
        check("rst_hlis", hlis_o, 8'h00);
        check("rst_int", int_o, 8'h00);
        reset = 1'b0;

        // Edge mode set / clear / re-arm
        pin = 8'h08;
        tick(); check("edge_lat1", irr_o, 8'h00);
        tick(); check("edge_lat2", irr_o, 8'h00);
        tick(); check("edge_set", irr_o, 8'h08);
        check("edge_int", int_o, 8'h08);
        clr = 8'h08; tick(); clr = 8'h00;
        check("edge_clr", irr_o, 8'h00);
        repeat (3) tick();
        check("edge_held", irr_o, 8'h00);
        pin = 8'h00; repeat (2) tick();
        pin = 8'h08; repeat (3) tick();
        check("edge_rearm", irr_o, 8'h08);
        clr = 8'h08; pin = 8'h00; tick(); clr = 8'h00;

        // Level mode
        cfg = 1'b1; pin = 8'h20;
        repeat (4) tick();
        check("lvl_set", irr_o, 8'h20);
        clr = 8'h20; tick(); clr = 8'h00;
        check("lvl_clr", irr_o & 8'h20, 8'h00);
        tick(); check("lvl_reset", irr_o & 8'h20, 8'h20);
        pin = 8'h00;
        tick(); tick(); check("lvl_fall_lat", irr_o, 8'h20);
        tick(); check("lvl_fall", irr_o, 8'h00);

        // Rotation and masking, IRR = 0x24
        pin = 8'h24; repeat (3) tick();
        check("rot_irr", irr_o, 8'h24);
        rot = 3'd7; #1 check("rot7", int_o, 8'h04);
        rot = 3'd2; #1 check("rot2", int_o, 8'h20);
        rot = 3'd7; mask = 8'h04; #1 check("mask04", int_o, 8'h20);
        mask = 8'h24; #1 check("mask24", int_o, 8'h00);
        mask = 8'h00;

        // Nesting with ISR = 0x02
        pin = 8'h02; repeat (3) tick();
        lat = 1'b1; tick(); lat = 1'b0;
        check("nest_isr", isr_o, 8'h02);
        #1 check("nest_equal", int_o, 8'h00);
        pin = 8'h08; repeat (3) tick();
        check("nest_lower", int_o, 8'h00);
        check("nest_hlis", hlis_o, 8'h02);
        pin = 8'h09; repeat (3) tick();
        check("nest_higher", int_o, 8'h01);
        lat = 1'b1; tick(); lat = 1'b0;
        check("isr_latch", isr_o, 8'h03);
        eoi = 8'h01; tick(); eoi = 8'h00;
        check("isr_eoi", isr_o, 8'h02);
        pin = 8'h04; repeat (3) tick();
        rot = 3'd1; #1 check("rot1_int", int_o, 8'h04);
        eoi = 8'h04; lat = 1'b1; tick(); lat = 1'b0; eoi = 8'h00;
        check("set_over_eoi", isr_o, 8'h06);
        eoi = 8'h06; rot = 3'd7; tick(); eoi = 8'h00;

        // Freeze in edge mode
        cfg = 1'b0; pin = 8'h00; repeat (3) tick();
        clr = 8'hFF; tick(); clr = 8'h00;
        frz = 1'b1; pin = 8'h40; tick(); pin = 8'h00;
        repeat (4) tick();
        check("frz_hold", irr_o, 8'h00);
        frz = 1'b0; tick();
        check("frz_release", irr_o, 8'h40);
        clr = 8'h40; tick(); clr = 8'h00;
        frz = 1'b1; pin = 8'h40; tick(); pin = 8'h00;
        repeat (3) tick();
        clr = 8'h40; tick(); clr = 8'h00;
        frz = 1'b0; tick();
        check("frz_clr", irr_o, 8'h00);
        tick();
        check("frz_clr2", irr_o, 8'h00);

        // Randomised traffic against the reference
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)  pin = 8'($urandom);
            if ($urandom_range(0, 15) == 0) cfg = ~cfg;
            frz  = ($urandom_range(0, 3) == 0);
            clr  = 8'($urandom & $urandom & $urandom);
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rot  = 3'($urandom);
            lat  = ($urandom_range(0, 2) == 0);
            eoi  = 8'($urandom & $urandom);
            tick();
        end

        // Asynchronous reset mid-sequence, line high at release counts as a rise
        pin = 8'hFF; cfg = 1'b0; frz = 1'b0; clr = 8'h00; mask = 8'h00;
        lat = 1'b0; eoi = 8'h00; rot = 3'd7;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_irr", irr_o, 8'h00);
        check("mid_rst_isr", isr_o, 8'h00);
        check("mid_rst_int", int_o, 8'h00);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) tick();
        check("rst_rise", irr_o, 8'hFF);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
